// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forward selects, load-use stall, store-data
// MEM-to-MEM forward. Define FWD_MEM2MEM_EN to bypass store-data load-use.
module fwd_hazard_unit #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_we,
  input  logic                      id_ld,
  input  logic                      id_st,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic                      flush,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
  output logic                      stall,
  output logic                      mem2mem_fwd,
  output logic [15:0]               stall_cnt
);

  logic [DEPTH-1:0]              v_q;
  logic [DEPTH-1:0]              we_q;
  logic [DEPTH-1:0][REG_AW-1:0]  rd_q;
  logic                          ld_q;
  logic [NUM_SRC-1:0][DEPTH-1:0] hit;
  logic [NUM_SRC-1:0]            lu;
  logic [NUM_SRC*SELW-1:0]       sel_d;
  logic [NUM_SRC*SELW-1:0]       sel_q;
  logic [15:0]                   cnt_q;
  logic                          m2m_case;
  logic                          load;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        hit[i][k] = v_q[k] & we_q[k] &
                    (|rd_q[k]) &
                    (rd_q[k] == id_src[i*REG_AW +: REG_AW]);
      end
    end
  end

  always_comb begin
    lu = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu[i] = hit[i][0] & ld_q;
    end
    lu[1] = lu[1] & ~m2m_case;
  end

  assign stall = id_valid & ~flush & (|lu);
  assign load  = id_valid & ~flush & ~stall;

  // Downward scan so the youngest matching slot wins.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[i][k] && !(i == 1 && k == 0 && m2m_case)) begin
          sel_d[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      we_q  <= '0;
      rd_q  <= '0;
      ld_q  <= 1'b0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= {v_q[DEPTH-2:0], load};
      we_q  <= {we_q[DEPTH-2:0], id_we};
      rd_q  <= {rd_q[DEPTH-2:0], id_rd};
      ld_q  <= id_ld;
      sel_q <= load ? sel_d : '0;
      if (stall && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign ex_fwd_sel = sel_q;
  assign stall_cnt  = cnt_q;

`ifdef FWD_MEM2MEM_EN
  logic m2m0_q;
  logic m2m_fwd_q;

  assign m2m_case = id_st & hit[1][0] & ld_q & ~hit[0][0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2m0_q    <= 1'b0;
      m2m_fwd_q <= 1'b0;
    end else begin
      m2m0_q    <= load & m2m_case;
      m2m_fwd_q <= v_q[0] & m2m0_q;
    end
  end

  assign mem2mem_fwd = m2m_fwd_q;
`else
  logic st_unused;

  assign st_unused   = id_st;
  assign m2m_case    = 1'b0;
  assign mem2mem_fwd = 1'b0;
`endif

endmodule
